seg_letter_rx: RTL

SEG_LETTER_RX -- requirements
Module: seg_letter_rx

---
 rtl/seg_letter_rx.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_letter_rx.sv
// seg_letter_rx: debounces an active-low seven-segment pattern, decodes it to a
// 5-bit letter code and presents it through an output register backed by one
// pending slot, with a sticky overflow flag for letters that had nowhere to go.
// Optional feature macro: SEG_LETTER_RX_SYNC_EN adds a 2-flop input synchronizer
// (two extra clocks of latency); without it seg_in is sampled directly.
module seg_letter_rx #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [4:0] letter,
  output logic       letter_err,
  output logic       letter_valid,
  input  logic       letter_ready,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam logic [6:0] BLANK    = 7'b1111111;
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_QUAL = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    FULL_PEND
  } out_state_t;

  // Decoded pattern as {err, code}; blank never reaches here because it is
  // never emitted.
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'b0001000: decode = {1'b0, 5'd1};
      7'b1100000: decode = {1'b0, 5'd2};
      7'b0110001: decode = {1'b0, 5'd3};
      7'b1000010: decode = {1'b0, 5'd4};
      7'b0110000: decode = {1'b0, 5'd5};
      7'b0111000: decode = {1'b0, 5'd6};
      7'b0100001: decode = {1'b0, 5'd7};
      7'b1101000: decode = {1'b0, 5'd8};
      7'b1000011: decode = {1'b0, 5'd9};
      7'b1110001: decode = {1'b0, 5'd10};
      7'b1101010: decode = {1'b0, 5'd11};
      7'b1100010: decode = {1'b0, 5'd12};
      7'b0011000: decode = {1'b0, 5'd13};
      7'b0001100: decode = {1'b0, 5'd14};
      7'b1111010: decode = {1'b0, 5'd15};
      7'b0100100: decode = {1'b0, 5'd16};
      7'b1000001: decode = {1'b0, 5'd17};
      7'b1000100: decode = {1'b0, 5'd18};
      7'b0101010: decode = {1'b0, 5'd0};
      default:    decode = {1'b1, 5'd0};
    endcase
  endfunction

  logic [6:0] s;

`ifdef SEG_LETTER_RX_SYNC_EN
  logic [6:0] sync1_q, sync1_d;
  logic [6:0] sync2_q, sync2_d;

  // Synchronizer shift: seg_in -> stage 1 -> stage 2.
  always_comb begin
    sync1_d = seg_in;
    sync2_d = sync1_q;
  end

  // Two-stage synchronizer, both stages resetting to blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= BLANK;
      sync2_q <= BLANK;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = seg_in;
`endif

  logic [6:0] prev_q, prev_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] last_q, last_d;
  logic       qualify;
  logic       emit;

  // Stability counter and last-emitted memory: a pattern qualifies once, when
  // it has been seen unchanged long enough, and emits only if it is new.
  always_comb begin
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    qualify = 1'b0;
    emit    = 1'b0;
    if (s != prev_q) begin
      prev_d = s;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 8'd1;
      end
      qualify = (cnt_q == CNT_QUAL);
    end
    if (qualify) begin
      if (s == BLANK) begin
        last_d = BLANK;
      end else if (s != last_q) begin
        emit   = 1'b1;
        last_d = s;
      end
    end
  end

  // Debounce state registers; blank marks "nothing emitted yet".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= BLANK;
      cnt_q  <= '0;
      last_q <= BLANK;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  out_state_t state_q, state_d;
  logic [4:0] out_code_q, out_code_d;
  logic       out_err_q, out_err_d;
  logic [4:0] pend_code_q, pend_code_d;
  logic       pend_err_q, pend_err_d;
  logic       ovf_q, ovf_d;
  logic [5:0] dec;
  logic       drop;

  // Output buffer FSM: output register plus one pending slot; an emit with
  // both slots full and no accept is dropped and flagged.
  always_comb begin
    state_d     = state_q;
    out_code_d  = out_code_q;
    out_err_d   = out_err_q;
    pend_code_d = pend_code_q;
    pend_err_d  = pend_err_q;
    ovf_d       = ovf_q;
    drop        = 1'b0;
    dec         = decode(s);
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    case (state_q)
      EMPTY: begin
        if (emit) begin
          out_code_d = dec[4:0];
          out_err_d  = dec[5];
          state_d    = FULL;
        end
      end
      FULL: begin
        if (letter_ready) begin
          if (emit) begin
            out_code_d = dec[4:0];
            out_err_d  = dec[5];
          end else begin
            state_d = EMPTY;
          end
        end else if (emit) begin
          pend_code_d = dec[4:0];
          pend_err_d  = dec[5];
          state_d     = FULL_PEND;
        end
      end
      FULL_PEND: begin
        if (letter_ready) begin
          out_code_d = pend_code_q;
          out_err_d  = pend_err_q;
          if (emit) begin
            pend_code_d = dec[4:0];
            pend_err_d  = dec[5];
          end else begin
            state_d = FULL;
          end
        end else if (emit) begin
          drop = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Output buffer registers; reset discards both slots and the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_code_q  <= '0;
      out_err_q   <= 1'b0;
      pend_code_q <= '0;
      pend_err_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_code_q  <= out_code_d;
      out_err_q   <= out_err_d;
      pend_code_q <= pend_code_d;
      pend_err_q  <= pend_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign letter       = out_code_q;
  assign letter_err   = out_err_q;
  assign letter_valid = (state_q != EMPTY);
  assign ovf          = ovf_q;

endmodule
